// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the M-stage data bridge.
package mem_bridge_pkg;

  // Bridge FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // Bus transfer size encodings.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical space.
  localparam logic [2:0]  KSEG0_TOP = 3'b100;
  localparam logic [2:0]  KSEG1_TOP = 3'b101;
  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

  // Byte lane of the lowest set enable bit; it becomes the low address bits.
  function automatic logic [1:0] lowest_lane(input logic [3:0] en);
    if (en[0])      lowest_lane = 2'd0;
    else if (en[1]) lowest_lane = 2'd1;
    else if (en[2]) lowest_lane = 2'd2;
    else if (en[3]) lowest_lane = 2'd3;
    else            lowest_lane = 2'd0;
  endfunction

endpackage

// File: rtl/mem_req_encode.sv
// Combinational request encoder: byte enables + virtual address ->
// direction, transfer size, physical byte address and write strobes.
module mem_req_encode
  import mem_bridge_pkg::*;
(
  input  logic [3:0]  i_rd_en,
  input  logic [3:0]  i_wr_en,
  input  logic [31:0] i_vaddr,
  output logic        o_wr,
  output logic [1:0]  o_size,
  output logic [31:0] o_paddr,
  output logic [3:0]  o_wstrb
);

  logic [3:0]  w_en;
  logic [31:0] w_mapped;

  // A store wins when both load and store enables are present.
  assign o_wr    = |i_wr_en;
  assign w_en    = o_wr ? i_wr_en : i_rd_en;
  assign o_wstrb = i_wr_en;

  // Size from the enable pattern; anything not word/half-aligned is a byte.
  always_comb begin
    o_size = SZ_BYTE;
    case (w_en)
      4'b1111:         o_size = SZ_WORD;
      4'b0011, 4'b1100: o_size = SZ_HALF;
      default:         o_size = SZ_BYTE;
    endcase
  end

  // Strip the segment bits for kseg0/kseg1, then place the lane index in [1:0].
  always_comb begin
    w_mapped = i_vaddr;
    if (i_vaddr[31:29] == KSEG0_TOP || i_vaddr[31:29] == KSEG1_TOP)
      w_mapped = i_vaddr & KSEG_MASK;
    o_paddr = (w_mapped & 32'hFFFF_FFFC) | {30'd0, lowest_lane(w_en)};
  end

endmodule

// File: rtl/data_sram_bridge.sv
// M-stage data bridge: turns a single-cycle byte-enabled load/store into an
// SRAM-like addr/data handshake, stalling the pipe until it completes and
// discarding responses that belong to flushed instructions.
// Handshake: the request is offered while bus_req=1 and is held unchanged
// until the cycle bus_addr_ok=1; exactly one response (bus_data_ok=1) follows
// in a later cycle. Only one transaction is ever outstanding.
module data_sram_bridge
  import mem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_rd_en,
  input  logic [3:0]  mem_wr_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_cancel,
  input  logic        pipe_adv,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  state_e      r_state;
  logic        r_cancel;
  logic        r_req;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_access;
  logic        w_cancel_pend;
  logic        w_enc_wr;
  logic [1:0]  w_enc_size;
  logic [31:0] w_enc_addr;
  logic [3:0]  w_enc_wstrb;

  assign w_access      = (|mem_rd_en) | (|mem_wr_en);
  assign w_cancel_pend = mem_cancel | r_cancel;

  mem_req_encode u_enc (
    .i_rd_en (mem_rd_en),
    .i_wr_en (mem_wr_en),
    .i_vaddr (mem_addr),
    .o_wr    (w_enc_wr),
    .o_size  (w_enc_size),
    .o_paddr (w_enc_addr),
    .o_wstrb (w_enc_wstrb)
  );

  // Bridge FSM plus request/response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cancel <= 1'b0;
      r_req    <= 1'b0;
      r_wr     <= 1'b0;
      r_size   <= 2'd0;
      r_addr   <= 32'd0;
      r_wstrb  <= 4'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cancel <= 1'b0;
          if (w_access && !mem_cancel) begin
            r_req   <= 1'b1;
            r_wr    <= w_enc_wr;
            r_size  <= w_enc_size;
            r_addr  <= w_enc_addr;
            r_wstrb <= w_enc_wstrb;
            r_wdata <= mem_wdata;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // The request may not be withdrawn, so a cancel is only remembered.
          if (mem_cancel) r_cancel <= 1'b1;
          if (bus_addr_ok) begin
            r_req   <= 1'b0;
            r_state <= w_cancel_pend ? ST_DRAIN : ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus_data_ok) begin
            if (w_cancel_pend) begin
              r_cancel <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              if (!r_wr) r_rdata <= bus_rdata;
              r_state <= ST_DONE;
            end
          end else if (mem_cancel) begin
            r_cancel <= 1'b1;
            r_state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus_data_ok) begin
            r_cancel <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (pipe_adv || mem_cancel) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall is combinational so the hazard unit sees it in the access cycle.
  assign mem_stall = rst & (((r_state == ST_IDLE) & w_access & ~mem_cancel) |
                            (r_state == ST_ADDR) | (r_state == ST_DATA) |
                            (r_state == ST_DRAIN));

  assign bus_req   = r_req;
  assign bus_wr    = r_wr;
  assign bus_size  = r_size;
  assign bus_addr  = r_addr;
  assign bus_wstrb = r_wstrb;
  assign bus_wdata = r_wdata;
  assign mem_rdata = r_rdata;

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Memory-stage data bridge between the MIPS core's data port and the SRAM-like data bus. Converts the core's single-cycle byte-enabled load/store into an address/data handshake and holds the pipeline via a stall request until the access completes. Also discards responses for instructions flushed by an exception. Sits directly downstream of the core's M stage, alongside the hazard unit that consumes its stall.

## Interface
Parameters: none.

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- mem_rd_en  in  4  M-stage load byte enables (0 = no load)
- mem_wr_en  in  4  M-stage store byte enables (0 = no store)
- mem_addr  in  32  M-stage virtual address (ALU result)
- mem_wdata  in  32  M-stage store data, already lane-aligned
- mem_cancel  in  1  M-stage instruction is being flushed
- pipe_adv  in  1  M stage latches a new instruction at this edge
- mem_rdata  out  32  raw returned word, held until pipe_adv
- mem_stall  out  1  stall request to hazard unit
- bus_req  out  1  request valid
- bus_wr  out  1  1 = write
- bus_size  out  2  0 byte, 1 half, 2 word
- bus_addr  out  32  physical byte address
- bus_wstrb  out  4  write strobes (= latched mem_wr_en)
- bus_wdata  out  32  write data
- bus_addr_ok  in  1  request accepted
- bus_data_ok  in  1  response / write ack
- bus_rdata  in  32  read data, valid with bus_data_ok

## Operation
- access = |mem_rd_en or |mem_wr_en. If both are nonzero, the access is a write.
- size: enables 4'b1111 → 2; 4'b0011 or 4'b1100 → 1; any one-hot value → 0.
- Low address bits = index of the lowest set enable bit.
- Address mapping: virtual addr[31:29] of 3'b100 or 3'b101 → physical = addr & 32'h1FFF_FFFF; all other addresses pass through unchanged.
- States: IDLE, ADDR, DATA, DONE, DRAIN.
- IDLE:
  - access & !mem_cancel → latch wr, size, physical addr, strobes and wdata into request registers; go to ADDR.
  - Otherwise stay in IDLE.
- ADDR: bus_req = 1 with the latched fields.
  - On bus_addr_ok, go to DATA, or to DRAIN if a cancel is pending.
  - bus_req must not be withdrawn before bus_addr_ok, even on cancel.
- DATA:
  - On bus_data_ok, capture bus_rdata into mem_rdata (reads only; writes leave mem_rdata unchanged).
  - Go to DONE, or to IDLE if a cancel is pending (response discarded).
  - mem_cancel without data_ok → DRAIN.
- DRAIN: wait for bus_data_ok, discard it, go to IDLE.
- DONE: pipe_adv → IDLE. mem_cancel in DONE → IDLE.
- Cancel pending = mem_cancel this cycle, or a sticky cancel flag set by mem_cancel in ADDR/DATA. The flag clears on return to IDLE.
- mem_stall = (IDLE & access & !mem_cancel) | ADDR | DATA | DRAIN. It is 0 in DONE.
- bus_data_ok in IDLE or DONE is ignored. bus_addr_ok outside ADDR is ignored.
- Only one transaction is outstanding at a time.

## Timing
- Reset (rst = 0): state IDLE, cancel flag 0, request registers 0, mem_rdata 0. All outputs 0.
- Asserting rst mid-transaction abandons it; any later bus responses land in IDLE and are ignored.
- Zero-wait bus: access visible in cycle 0; bus_req in cycle 1 with addr_ok; data_ok in cycle 2; DONE in cycle 3. mem_stall is high for cycles 0–2 (3 cycles) and mem_rdata is valid from cycle 3.
- bus_data_ok is never expected in the same cycle as bus_addr_ok; the earliest response is one cycle later.
- Each additional addr_ok or data_ok wait cycle adds exactly one stall cycle.
- Bus outputs are registered. mem_stall is combinational from state and the mem_* inputs.
- The core holds all mem_* inputs stable while mem_stall = 1.

## Structure
- Shared package mem_bridge_pkg holds:
  - the state enum (IDLE, ADDR, DATA, DONE, DRAIN);
  - size constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - kseg masks: 3'b100, 3'b101, 32'h1FFF_FFFF.
- One natural sub-module: mem_req_encode, which is purely combinational: enables + virtual address → wr, size, physical address, strobes.
- The FSM and the request/response registers stay in data_sram_bridge.

## Test plan
- Word load: rd_en = 4'b1111, addr = 32'h8000_1004, zero-wait bus with rdata = 32'hDEAD_BEEF → bus_addr = 32'h0000_1004, size = 2, stall for 3 cycles, mem_rdata = 32'hDEADBEEF until pipe_adv.
- Byte store: wr_en = 4'b0100, addr = 32'hBFC0_0010, wdata = 32'h00AB_0000 → bus_wr = 1, size = 0, bus_addr = 32'h1FC0_0012, wstrb = 4'b0100.
- Wait states: addr_ok delayed 2 cycles and data_ok delayed 3 cycles after acceptance → stall lasts 3 + 5 = 8 cycles; bus_req is held steady until addr_ok.
- Cancel in DATA: mem_cancel pulses for one cycle before data_ok; data_ok then arrives with 32'h1234_5678 → mem_rdata unchanged; the block returns to IDLE; the next load issues normally.
- Cancel in ADDR before addr_ok → bus_req stays high until addr_ok; the FSM waits in DRAIN for the response; no data is captured.
- Reset mid-DATA: rst low → all outputs 0 immediately; a later stray data_ok is ignored; mem_stall stays 0 with no access.
